// File: rtl/tdd_frame_timer_pkg.sv
// Shared widths and register reset defaults for the TDD frame timer slice.
package tdd_frame_timer_pkg;

  localparam int unsigned CW_DEF        = 24;
  localparam int unsigned FCW_DEF       = 32;

  localparam int unsigned FRAME_LEN_RST = 1920;
  localparam int unsigned TSTART_RST    = 0;
  localparam int unsigned TEND_RST      = 1919;
  localparam int unsigned RSTART_RST    = 0;
  localparam int unsigned REND_RST      = 1919;

endpackage

// File: rtl/tdd_frame_timer_window_cmp.sv
// Inclusive window match on a sample index; start > end selects a wrap-around window.
module tdd_window_cmp
  import tdd_frame_timer_pkg::*;
#(
  parameter int unsigned CW = CW_DEF
) (
  input  logic [CW-1:0] i_start,
  input  logic [CW-1:0] i_end,
  input  logic [CW-1:0] i_cnt,
  output logic          o_match_c
);

  assign o_match_c = (i_start <= i_end) ? ((i_cnt >= i_start) && (i_cnt <= i_end))
                                        : ((i_cnt >= i_start) || (i_cnt <= i_end));

endmodule

// File: rtl/tdd_frame_timer.sv
// Sample-rate frame counter with shadowed TX/RX windows and one-shot phase adjust.
// Optional TX-priority overlap guard with sticky overlap_err: define TDD_OVERLAP_GUARD_EN.
module tdd_frame_timer
  import tdd_frame_timer_pkg::*;
#(
  parameter int unsigned CW  = CW_DEF,
  parameter int unsigned FCW = FCW_DEF
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           run,
  input  logic           smp_en,
  input  logic           tddmode,
  input  logic [CW-1:0]  frame_len,
  input  logic [CW-1:0]  frame_adj,
  input  logic           adj_wr,
  input  logic [CW-1:0]  tstart,
  input  logic [CW-1:0]  tend,
  input  logic [CW-1:0]  rstart,
  input  logic [CW-1:0]  rend,
  output logic [CW-1:0]  cnt,
  output logic [FCW-1:0] frame_cnt,
  output logic           frame_sync,
  output logic           tx_en,
  output logic           rx_en,
  output logic           adj_pending
`ifdef TDD_OVERLAP_GUARD_EN
  ,
  output logic           overlap_err
`endif
);

  logic           r_run_d;
  logic [CW-1:0]  r_cnt;
  logic [CW-1:0]  r_len;
  logic [CW-1:0]  r_ts;
  logic [CW-1:0]  r_te;
  logic [CW-1:0]  r_rs;
  logic [CW-1:0]  r_re;
  logic [CW-1:0]  r_adj_val;
  logic [FCW-1:0] r_frame_cnt;
  logic           r_frame_sync;
  logic           r_tx_en;
  logic           r_rx_en;
  logic           r_adj_pending;

  logic           w_load;
  logic           w_step;
  logic           w_bnd;
  logic           w_reload;
  logic           w_adj_ok;
  logic           w_tx_m;
  logic           w_rx_m;
  logic           w_tx_nxt;
  logic           w_rx_nxt;
  logic [CW-1:0]  w_cur_len;
  logic [CW-1:0]  w_new_len;
  logic [CW-1:0]  w_cnt_nxt;
  logic [CW-1:0]  w_ts;
  logic [CW-1:0]  w_te;
  logic [CW-1:0]  w_rs;
  logic [CW-1:0]  w_re;

  // First run cycle only loads shadows and parks cnt at 0 so the gates are valid for sample 0.
  assign w_load    = run & ~r_run_d;
  assign w_step    = run & r_run_d & smp_en;
  assign w_cur_len = (r_len == '0) ? CW'(1) : r_len;
  assign w_new_len = (frame_len == '0) ? CW'(1) : frame_len;
  assign w_bnd     = w_step & (r_cnt == (w_cur_len - CW'(1)));
  assign w_reload  = w_load | w_bnd;
  assign w_adj_ok  = r_adj_pending & (r_adj_val < w_new_len);

  always_comb begin
    w_cnt_nxt = r_cnt + CW'(1);
    if (w_load) begin
      w_cnt_nxt = '0;
    end else if (w_bnd) begin
      w_cnt_nxt = w_adj_ok ? r_adj_val : '0;
    end
  end

  // Bounds that will be in force for the next cnt value.
  assign w_ts = w_reload ? tstart : r_ts;
  assign w_te = w_reload ? tend   : r_te;
  assign w_rs = w_reload ? rstart : r_rs;
  assign w_re = w_reload ? rend   : r_re;

  tdd_window_cmp #(.CW(CW)) u_tx_win (
    .i_start   (w_ts),
    .i_end     (w_te),
    .i_cnt     (w_cnt_nxt),
    .o_match_c (w_tx_m)
  );

  tdd_window_cmp #(.CW(CW)) u_rx_win (
    .i_start   (w_rs),
    .i_end     (w_re),
    .i_cnt     (w_cnt_nxt),
    .o_match_c (w_rx_m)
  );

  assign w_tx_nxt = tddmode ? w_tx_m : 1'b1;
`ifdef TDD_OVERLAP_GUARD_EN
  assign w_rx_nxt = tddmode ? (w_rx_m & ~w_tx_m) : 1'b1;
`else
  assign w_rx_nxt = tddmode ? w_rx_m : 1'b1;
`endif

  // Adjust request survives run deassert; a write on a boundary cycle stays pending.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_adj_val     <= '0;
      r_adj_pending <= 1'b0;
    end else if (adj_wr) begin
      r_adj_val     <= frame_adj;
      r_adj_pending <= 1'b1;
    end else if (w_bnd) begin
      r_adj_pending <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_run_d      <= 1'b0;
      r_cnt        <= '0;
      r_frame_cnt  <= '0;
      r_frame_sync <= 1'b0;
      r_tx_en      <= 1'b0;
      r_rx_en      <= 1'b0;
      r_len        <= '0;
      r_ts         <= '0;
      r_te         <= '0;
      r_rs         <= '0;
      r_re         <= '0;
    end else begin
      r_run_d      <= run;
      r_frame_sync <= w_bnd;
      if (!run) begin
        r_cnt       <= '0;
        r_frame_cnt <= '0;
        r_tx_en     <= 1'b0;
        r_rx_en     <= 1'b0;
      end else if (w_load || w_step) begin
        r_cnt       <= w_cnt_nxt;
        r_frame_cnt <= w_load ? '0 : (r_frame_cnt + FCW'(w_bnd));
        r_tx_en     <= w_tx_nxt;
        r_rx_en     <= w_rx_nxt;
        if (w_reload) begin
          r_len <= frame_len;
          r_ts  <= tstart;
          r_te  <= tend;
          r_rs  <= rstart;
          r_re  <= rend;
        end
      end
    end
  end

`ifdef TDD_OVERLAP_GUARD_EN
  logic w_ovl;
  logic r_overlap_err;

  assign w_ovl = tddmode & w_tx_m & w_rx_m;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_overlap_err <= 1'b0;
    end else if (w_load) begin
      r_overlap_err <= w_ovl;
    end else if (w_step && w_ovl) begin
      r_overlap_err <= 1'b1;
    end
  end

  assign overlap_err = r_overlap_err;
`endif

  assign cnt         = r_cnt;
  assign frame_cnt   = r_frame_cnt;
  assign frame_sync  = r_frame_sync;
  assign tx_en       = r_tx_en;
  assign rx_en       = r_rx_en;
  assign adj_pending = r_adj_pending;

endmodule

// File: tb/tb_tdd_frame_timer.sv
// Directed bench for tdd_frame_timer: sample-level reference model plus literal checkpoints.
module tb_tdd_frame_timer;

  localparam int unsigned CW  = 24;
  localparam int unsigned FCW = 32;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           run = 1'b0;
  logic           smp_en = 1'b0;
  logic           tddmode = 1'b0;
  logic [CW-1:0]  frame_len = '0;
  logic [CW-1:0]  frame_adj = '0;
  logic           adj_wr = 1'b0;
  logic [CW-1:0]  tstart = '0;
  logic [CW-1:0]  tend = '0;
  logic [CW-1:0]  rstart = '0;
  logic [CW-1:0]  rend = '0;
  logic [CW-1:0]  cnt;
  logic [FCW-1:0] frame_cnt;
  logic           frame_sync;
  logic           tx_en;
  logic           rx_en;
  logic           adj_pending;
`ifdef TDD_OVERLAP_GUARD_EN
  logic           overlap_err;
`endif

  int n_vec = 0;
  int n_err = 0;

  tdd_frame_timer #(.CW(CW), .FCW(FCW)) dut (
    .clk         (clk),
    .rst         (rst),
    .run         (run),
    .smp_en      (smp_en),
    .tddmode     (tddmode),
    .frame_len   (frame_len),
    .frame_adj   (frame_adj),
    .adj_wr      (adj_wr),
    .tstart      (tstart),
    .tend        (tend),
    .rstart      (rstart),
    .rend        (rend),
    .cnt         (cnt),
    .frame_cnt   (frame_cnt),
    .frame_sync  (frame_sync),
    .tx_en       (tx_en),
    .rx_en       (rx_en),
    .adj_pending (adj_pending)
`ifdef TDD_OVERLAP_GUARD_EN
    ,
    .overlap_err (overlap_err)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic bit in_win(input int s, input int e, input int c);
    if (s <= e) return (c >= s) && (c <= e);
    return (c >= s) || (c <= e);
  endfunction

  // Reference model: what each sample does to the timer, stated directly from the rules.
  int        m_cnt = 0;
  bit [31:0] m_fc = 0;
  bit        m_sync = 0, m_tx = 0, m_rx = 0, m_pend = 0, m_ovl = 0, m_run_d = 0;
  int        m_adjv = 0;
  int        s_len = 0, s_ts = 0, s_te = 0, s_rs = 0, s_re = 0;
  int        m_L;
  bit        m_gate_upd;

  always @(posedge clk) begin
    if (rst) begin
      m_cnt = 0; m_fc = 0; m_sync = 0; m_tx = 0; m_rx = 0; m_pend = 0; m_ovl = 0;
      m_run_d = 0; m_adjv = 0; s_len = 0; s_ts = 0; s_te = 0; s_rs = 0; s_re = 0;
    end else begin
      m_sync = 0;
      m_gate_upd = 0;
      if (!run) begin
        m_cnt = 0; m_fc = 0; m_tx = 0; m_rx = 0;
      end else if (!m_run_d) begin
        s_len = int'(frame_len); s_ts = int'(tstart); s_te = int'(tend);
        s_rs = int'(rstart); s_re = int'(rend);
        m_cnt = 0; m_fc = 0; m_gate_upd = 1; m_ovl = 0;
      end else if (smp_en) begin
        m_L = (s_len == 0) ? 1 : s_len;
        if (m_cnt == m_L - 1) begin
          s_len = int'(frame_len); s_ts = int'(tstart); s_te = int'(tend);
          s_rs = int'(rstart); s_re = int'(rend);
          m_L = (s_len == 0) ? 1 : s_len;
          m_cnt = (m_pend && m_adjv < m_L) ? m_adjv : 0;
          m_pend = 0;
          m_fc = m_fc + 1;
          m_sync = 1;
        end else begin
          m_cnt = m_cnt + 1;
        end
        m_gate_upd = 1;
      end
      if (m_gate_upd) begin
        m_tx = tddmode ? in_win(s_ts, s_te, m_cnt) : 1'b1;
        m_rx = tddmode ? in_win(s_rs, s_re, m_cnt) : 1'b1;
`ifdef TDD_OVERLAP_GUARD_EN
        if (tddmode && m_tx && m_rx) begin
          m_rx = 0;
          m_ovl = 1;
        end
`endif
      end
      if (adj_wr) begin
        m_pend = 1;
        m_adjv = int'(frame_adj);
      end
      m_run_d = run;
    end
  end

  // Compare every output against the model away from the active edge.
  always @(negedge clk) begin
    if (!rst) begin
      chk("cnt", longint'(cnt), longint'(m_cnt));
      chk("frame_cnt", longint'(frame_cnt), longint'(m_fc));
      chk("frame_sync", longint'(frame_sync), longint'(m_sync));
      chk("tx_en", longint'(tx_en), longint'(m_tx));
      chk("rx_en", longint'(rx_en), longint'(m_rx));
      chk("adj_pending", longint'(adj_pending), longint'(m_pend));
`ifdef TDD_OVERLAP_GUARD_EN
      chk("overlap_err", longint'(overlap_err), longint'(m_ovl));
`endif
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic restart();
    run = 1'b0;
    tick();
    run = 1'b1;
    tick();
  endtask

  task automatic set_win(input int ts, input int te, input int rs, input int re);
    tstart = CW'(ts); tend = CW'(te); rstart = CW'(rs); rend = CW'(re);
  endtask

  int seq_a[6]  = '{6, 7, 8, 9, 3, 4};
  bit pnd_a[6]  = '{1, 1, 1, 1, 0, 0};
  int seq_b[7]  = '{5, 6, 7, 8, 9, 0, 1};
  bit pnd_b[7]  = '{1, 1, 1, 1, 1, 0, 0};
  int seq_c[14] = '{4, 5, 6, 7, 8, 9, 0, 1, 2, 3, 4, 5, 0, 1};
  int c;

  initial begin
    repeat (2) tick();
    chk("rst_cnt", longint'(cnt), 0);
    chk("rst_fc", longint'(frame_cnt), 0);
    chk("rst_tx", longint'(tx_en), 0);
    chk("rst_pend", longint'(adj_pending), 0);
    rst = 1'b0;
    tick();

    // FDD free-run, frame_len 8
    frame_len = CW'(8); tddmode = 1'b0; smp_en = 1'b1; set_win(0, 7, 0, 7);
    run = 1'b1;
    tick();
    chk("fdd_start_cnt", longint'(cnt), 0);
    chk("fdd_start_tx", longint'(tx_en), 1);
    repeat (24) tick();
    chk("fdd_fc3", longint'(frame_cnt), 3);
    chk("fdd_cnt0", longint'(cnt), 0);
    chk("fdd_sync", longint'(frame_sync), 1);
    chk("fdd_rx", longint'(rx_en), 1);
    run = 1'b0;
    tick();
    chk("run_off_cnt", longint'(cnt), 0);
    chk("run_off_fc", longint'(frame_cnt), 0);
    chk("run_off_tx", longint'(tx_en), 0);

    // TDD windows T=[2,4] R=[6,9]
    frame_len = CW'(10); tddmode = 1'b1; set_win(2, 4, 6, 9);
    restart();
    for (int j = 0; j < 20; j++) begin
      if (j > 0) tick();
      c = j % 10;
      chk("tdd_cnt", longint'(cnt), longint'(c));
      chk("tdd_tx", longint'(tx_en), longint'(c >= 2 && c <= 4));
      chk("tdd_rx", longint'(rx_en), longint'(c >= 6 && c <= 9));
    end

    // Wrap window T=[8,1]
    set_win(8, 1, 11, 12);
    restart();
    for (int j = 0; j < 20; j++) begin
      if (j > 0) tick();
      c = j % 10;
      chk("wrap_tx", longint'(tx_en), longint'(c >= 8 || c <= 1));
      chk("wrap_rx_oob", longint'(rx_en), 0);
    end

    // Adjust to 3 requested at cnt 5
    tddmode = 1'b0;
    restart();
    repeat (5) tick();
    chk("adj_at5", longint'(cnt), 5);
    adj_wr = 1'b1; frame_adj = CW'(3);
    for (int k = 0; k < 6; k++) begin
      tick();
      adj_wr = 1'b0;
      chk("adj3_cnt", longint'(cnt), longint'(seq_a[k]));
      chk("adj3_pend", longint'(adj_pending), longint'(pnd_a[k]));
    end
    // Out-of-range adjust loads 0
    adj_wr = 1'b1; frame_adj = CW'(12);
    for (int k = 0; k < 7; k++) begin
      tick();
      adj_wr = 1'b0;
      chk("adj12_cnt", longint'(cnt), longint'(seq_b[k]));
      chk("adj12_pend", longint'(adj_pending), longint'(pnd_b[k]));
    end
    // Adjust written on the boundary cycle waits one more frame
    repeat (8) tick();
    chk("adjb_pre", longint'(cnt), 9);
    adj_wr = 1'b1; frame_adj = CW'(2);
    tick();
    adj_wr = 1'b0;
    chk("adjb_cnt0", longint'(cnt), 0);
    chk("adjb_pend", longint'(adj_pending), 1);
    repeat (10) tick();
    chk("adjb_cnt2", longint'(cnt), 2);
    chk("adjb_clr", longint'(adj_pending), 0);

    // Shadowing plus smp_en hold
    tddmode = 1'b1; set_win(2, 4, 6, 9); frame_len = CW'(10);
    restart();
    repeat (3) tick();
    smp_en = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("hold_cnt", longint'(cnt), 3);
      chk("hold_tx", longint'(tx_en), 1);
    end
    smp_en = 1'b1; frame_len = CW'(6);
    for (int k = 0; k < 14; k++) begin
      tick();
      chk("shadow_cnt", longint'(cnt), longint'(seq_c[k]));
    end

    // Zero length behaves as length 1
    frame_len = '0; set_win(3, 5, 3, 5);
    restart();
    repeat (5) tick();
    chk("len0_fc", longint'(frame_cnt), 5);
    chk("len0_cnt", longint'(cnt), 0);
    chk("len0_tx", longint'(tx_en), 0);

`ifdef TDD_OVERLAP_GUARD_EN
    frame_len = CW'(8); tddmode = 1'b1; set_win(0, 5, 4, 7);
    restart();
    for (int j = 0; j < 8; j++) begin
      if (j > 0) tick();
      chk("ovl_rx", longint'(rx_en), longint'(j >= 6));
      chk("ovl_err", longint'(overlap_err), longint'(j >= 4));
    end
`endif

    // Mixed traffic: model-checked only
    frame_len = CW'(7); set_win(1, 3, 5, 2);
    restart();
    for (int j = 0; j < 400; j++) begin
      smp_en = ($urandom_range(0, 3) != 0);
      adj_wr = ($urandom_range(0, 15) == 0);
      frame_adj = CW'($urandom_range(0, 12));
      if ($urandom_range(0, 19) == 0) frame_len = CW'($urandom_range(0, 12));
      if ($urandom_range(0, 19) == 0)
        set_win($urandom_range(0, 12), $urandom_range(0, 12),
                $urandom_range(0, 12), $urandom_range(0, 12));
      if ($urandom_range(0, 49) == 0) tddmode = ~tddmode;
      run = ($urandom_range(0, 63) != 0);
      tick();
    end
    adj_wr = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/tdd_frame_timer.md
Name: tdd_frame_timer

Overview:
- Sample-rate frame timer fed by the AXI2S control register block: consumes FRAME_LEN, FRAME_ADJ, TSTART/TEND, RSTART/REND and the tddmode bit.
- Produces the TX/RX gate strobes that qualify the AXI-to-stream and stream-to-AXI datapaths, a per-frame sync pulse, and adj_pending, which the register block reports as AXI2S_STATE[3].
- Counts samples modulo frame length, with a one-shot phase adjustment and glitch-free shadowed window updates.

Parameters:
CW, 24, width of sample counter and all length/window fields
FCW, 32, width of frame counter

Ports:
clk  in  1  clock
rst  in  1  reset: asynchronous, active-high
run  in  1  timer enable (register block ien|oen); low = counter held at 0, outputs low
smp_en  in  1  sample strobe; counter advances only when high
tddmode  in  1  1 = TDD windowing active, 0 = FDD (tx_en=rx_en=run)
frame_len  in  CW  samples per frame
frame_adj  in  CW  phase value loaded at next frame boundary
adj_wr  in  1  single-cycle pulse when FRAME_ADJ is written
tstart, tend  in  CW each  TX window bounds, inclusive
rstart, rend  in  CW each  RX window bounds, inclusive
cnt  out  CW  current sample index
frame_cnt  out  FCW  frames completed since run rose
frame_sync  out  1  one-cycle pulse on the smp_en cycle where cnt wraps to frame start
tx_en  out  1  TX gate, registered
rx_en  out  1  RX gate, registered
adj_pending  out  1  adjustment requested, not yet applied

Behaviour:
- Reset: cnt=0, frame_cnt=0, frame_sync=0, tx_en=0, rx_en=0, adj_pending=0, all shadow registers=0.
- Shadowing:
  - On the run 0->1 edge and on every frame boundary, frame_len, tstart, tend, rstart and rend are copied into shadows.
  - Mid-frame register writes take effect only at the next boundary.
- Effective length L = max(shadow frame_len, 1).
- Counting, when run=1 and smp_en=1:
  - If cnt == L-1 (boundary), load cnt = (adj_pending ? adj_val : 0), increment frame_cnt (wraps mod 2^FCW), and pulse frame_sync.
  - Otherwise cnt increments.
  - If smp_en=0, all state holds.
- Adjust:
  - adj_wr latches frame_adj into adj_val and sets adj_pending.
  - At the next boundary, cnt loads adj_val and adj_pending clears. If adj_val >= L, cnt loads 0 instead.
  - adj_wr in the same cycle as a boundary: the boundary uses the old adj state; the new request stays pending until the following boundary.
  - A second adj_wr before the boundary overwrites adj_val.
- run deassert: synchronously clears cnt, frame_cnt, frame_sync, tx_en and rx_en on the next clk. adj_pending and adj_val are kept.
- Windows, evaluated on the next-cycle cnt value with shadowed bounds:
  - in_win(s,e) = (s<=e) ? (s<=cnt && cnt<=e) : (cnt>=s || cnt<=e). The else branch handles wrap-around windows.
  - tx_en = run & (tddmode ? in_win(tstart,tend) : 1); rx_en likewise with rstart/rend.
  - Registered so the gates align with cnt: both change in the same cycle cnt changes. No extra latency relative to cnt.
- Bounds >= L never match when s<=e. For wrap windows only the matching side is active.
- tddmode is sampled directly, not shadowed; a toggle takes effect on the next smp_en cycle.

Optional Feature:
TDD_OVERLAP_GUARD_EN
- Defined:
  - When TX and RX windows both match, rx_en is forced 0 (TX priority).
  - Adds output overlap_err (1 bit, sticky), set on the first overlapping cycle. It clears only on rst or a run 0->1 edge.
- Undefined: tx_en and rx_en are independent and may both be 1; the overlap_err port is absent.

Decomposition:
- Shared package (reg_define include): CW/FCW defaults and reset defaults FRAME_LEN_RST=1920, TEND_RST=REND_RST=1919, TSTART_RST=RSTART_RST=0.
- One sub-module, tdd_window_cmp: combinational in_win(s,e,cnt) comparator, instanced twice (TX, RX).

Test Plan:
- FDD free-run: run=1, smp_en=1 always, tddmode=0, frame_len=8 -> cnt cycles 0..7, frame_sync high when cnt goes 7->0, frame_cnt=3 after 24 samples, tx_en=rx_en=1 throughout.
- TDD windows: frame_len=10, T=[2,4], R=[6,9] -> tx_en high exactly at cnt 2,3,4; rx_en high at 6..9; both low at 0,1,5.
- Wrap window: frame_len=10, T=[8,1] -> tx_en high at cnt 8,9,0,1 only.
- Adjust: frame_len=10, adj_wr with frame_adj=3 at cnt=5 -> adj_pending=1 until the boundary, then cnt sequence 9,3,4…; adj_pending=0. Repeat with frame_adj=12 -> cnt loads 0.
- Shadowing: change frame_len 10->6 at cnt=3 -> the current frame still ends at 9, the next frame wraps at 5. Drop smp_en for 5 cycles -> cnt and tx_en hold.
- With TDD_OVERLAP_GUARD_EN: T=[0,5], R=[4,7] -> rx_en low at cnt 4,5, high at 6,7; overlap_err set at the first cnt=4 and stays 1.
